// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a word-organised data memory with sub-word RMW stores.
// Define MISALIGN_TRAP_EN to reject misaligned/reserved requests instead of aligning down.
module lsu_mem_initiator #(
   parameter int ADDR_W = 10,
   parameter int XLEN   = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [31:0]     req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic [31:0]     mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic            mem_we,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            busy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RD     = 3'd1;
   localparam logic [2:0] RMW_RD = 3'd2;
   localparam logic [2:0] WR     = 3'd3;
   localparam logic [2:0] RESP   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [1:0]        lane_q;
   logic [1:0]        size_q;
   logic              we_q;
   logic              uns_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   old_q;
   logic [XLEN-1:0]   rdata_q;
   logic              err_q;
   logic              accept;
   logic              sub_st;
   logic              mis;
   logic              unused_addr;

   assign unused_addr = ^req_addr[31:ADDR_W+2];

   function automatic logic [31:0] load_fmt(input logic [31:0] w,
                                            input logic [1:0]  ln,
                                            input logic [1:0]  sz,
                                            input logic        u);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{ln, 3'b000} +: 8];
      h = w[{ln[1], 4'b0000} +: 16];
      unique case (1'b1)
         sz == 2'b00: load_fmt = {{24{b[7] & ~u}}, b};
         sz == 2'b01: load_fmt = {{16{h[15] & ~u}}, h};
         default:     load_fmt = w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [1:0]  ln,
                                         input logic [1:0]  sz);
      merge = old;
      unique case (1'b1)
         sz == 2'b00: merge[{ln, 3'b000} +: 8] = wd[7:0];
         sz == 2'b01: merge[{ln[1], 4'b0000} +: 16] = wd[15:0];
         default:     merge = wd;
      endcase
   endfunction

   assign req_ready = (state_q == IDLE) & rst;
   assign accept    = req_valid & req_ready;
   assign sub_st    = (req_size == 2'b00) | (req_size == 2'b01);

`ifdef MISALIGN_TRAP_EN
   assign mis = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (|req_addr[1:0]));
`else
   assign mis = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (mis)         state_d = RESP;
               else if (!req_we) state_d = RD;
               else if (sub_st)  state_d = RMW_RD;
               else              state_d = WR;
            end
         end
         RD:      state_d = RESP;
         RMW_RD:  state_d = WR;
         WR:      state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         old_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            idx_q   <= req_addr[ADDR_W+1:2];
            lane_q  <= req_addr[1:0];
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= mis;
         end
         if (state_q == RMW_RD) old_q <= mem_rdata;
         if (state_q == RD)
            rdata_q <= load_fmt(mem_rdata, lane_q, size_q, uns_q);
      end
   end

   // Memory outputs decode straight from state so reset kills mem_we at once.
   assign mem_we    = (state_q == WR);
   assign mem_wdata = mem_we ? merge(old_q, wdata_q, lane_q, size_q) : '0;
   assign mem_addr  = ((state_q == RD) | (state_q == RMW_RD) | mem_we)
                    ? {{(32-ADDR_W){1'b0}}, idx_q} : '0;

   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_valid ? rdata_q : '0;
`ifdef MISALIGN_TRAP_EN
   assign resp_err   = resp_valid & err_q;
`else
   assign resp_err   = 1'b0;
`endif
   assign busy       = (state_q != IDLE);

   logic unused_we;
   assign unused_we = we_q ^ err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed table, corner sequences, random vs byte-level model.
// Honours MISALIGN_TRAP_EN when the same define is given to the bench build.
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, busy;

   int errs = 0;
   int checks = 0;

   logic [31:0] mem [0:1023];
   logic [7:0]  rb [0:4095];

   always #5 clk = ~clk;

   lsu_mem_initiator dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
   );

   assign mem_rdata = mem[mem_addr[9:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] ad;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [31:0] wdx;
   } vec_t;

   function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endfunction

   // Byte-level reference: memory is a flat byte array of 4 KiB.
   function automatic void model(input logic we, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] ad,
                                 input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er,
                                 output int lat, output int nwe,
                                 output logic [31:0] wa,
                                 output logic [31:0] wdat);
      int n, base, wb;
      logic [31:0] v;
      n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      er = 1'b0;
`ifdef MISALIGN_TRAP_EN
      er = (sz == 3) || (sz == 1 && ad[0]) || (sz == 2 && ad[1:0] != 0);
`endif
      rd = 0; nwe = 0; wa = 0; wdat = 0; lat = 1;
      if (er) return;
      base = int'(ad & 32'hFFF) & ~(n - 1);
      if (we) begin
         for (int j = 0; j < n; j++) rb[base + j] = wd[8*j +: 8];
         lat = (n == 4) ? 2 : 3;
         nwe = 1;
         wa = base / 4;
         wb = base & ~3;
         wdat = {rb[wb+3], rb[wb+2], rb[wb+1], rb[wb]};
      end else begin
         v = 0;
         for (int j = 0; j < n; j++) v = v | (32'(rb[base + j]) << (8*j));
         if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
         rd = v;
         lat = 2;
      end
   endfunction

   // Entered and left on a negedge.
   task automatic do_req(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] ad,
                         input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int nwe, output int wcyc,
                         output logic [31:0] wa, output logic [31:0] wdat);
      int k;
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
      req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = ad; req_wdata = wd;
      @(posedge clk); #1 req_valid = 0;
      lat = 0; nwe = 0; wcyc = 0; wa = 0; wdat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_we) begin nwe++; wcyc = lat; wa = mem_addr; wdat = mem_wdata; end
      end while (!resp_valid && lat < 10);
      rd = resp_rdata; er = resp_err;
      resp_ready = 1;
      @(posedge clk); #1 resp_ready = 0;
      @(negedge clk);
      chk("req_ready_after_resp", {31'b0, req_ready}, 32'd1);
   endtask

   task automatic run_op(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] ad,
                         input logic [31:0] wd, input bit cmp,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int nwe,
                         output logic [31:0] wa, output logic [31:0] wdat);
      logic [31:0] erd, ewa, ewd;
      logic eer;
      int elat, enwe, wcyc;
      model(we, sz, uns, ad, wd, erd, eer, elat, enwe, ewa, ewd);
      do_req(we, sz, uns, ad, wd, rd, er, lat, nwe, wcyc, wa, wdat);
      if (cmp) begin
         chk("rnd_rdata", rd, erd);
         chk("rnd_err", {31'b0, er}, {31'b0, eer});
         chk("rnd_lat", lat, elat);
         chk("rnd_nwe", nwe, enwe);
         if (enwe != 0) begin
            chk("rnd_wcyc", wcyc, elat - 1);
            chk("rnd_waddr", wa, ewa);
            chk("rnd_wdata", wdat, ewd);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      logic [31:0] rd, wa, wdat, hold;
      logic er;
      int lat, nwe, k;

      for (int i = 0; i < 1024; i++) mem[i] = 0;
      for (int i = 0; i < 4096; i++) rb[i] = 0;

      // Reset held with a pending request
      rst = 0; req_valid = 1; req_we = 0; req_size = 2; req_unsigned = 0;
      req_addr = 0; req_wdata = 0; resp_ready = 0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_req_ready", {31'b0, req_ready}, 0);
         chk("rst_mem_we", {31'b0, mem_we}, 0);
         chk("rst_resp_valid", {31'b0, resp_valid}, 0);
      end
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      req_valid = 0;
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      chk("rel_req_ready", {31'b0, req_ready}, 1);

      for (int i = 0; i < 16; i++)
         run_op(1, 2, 0, i * 4, 0, 0, rd, er, lat, nwe, wa, wdat);

      tbl.push_back(vec_t'{1, 2, 0, 'h10, 'hDEADBEEF, 0, 0, 2, 'hDEADBEEF});
      tbl.push_back(vec_t'{0, 2, 0, 'h10, 0, 'hDEADBEEF, 0, 2, 0});
      tbl.push_back(vec_t'{1, 2, 0, 'h20, 'h11223344, 0, 0, 2, 'h11223344});
      tbl.push_back(vec_t'{1, 0, 0, 'h22, 'hAA, 0, 0, 3, 'h11AA3344});
      tbl.push_back(vec_t'{0, 2, 0, 'h20, 0, 'h11AA3344, 0, 2, 0});
      tbl.push_back(vec_t'{1, 1, 0, 'h22, 'h1234CAFE, 0, 0, 3, 'hCAFE3344});
      tbl.push_back(vec_t'{1, 2, 0, 'h30, 'h8000F07F, 0, 0, 2, 'h8000F07F});
      tbl.push_back(vec_t'{0, 0, 0, 'h30, 0, 'h7F, 0, 2, 0});
      tbl.push_back(vec_t'{0, 0, 0, 'h31, 0, 'hFFFFFFF0, 0, 2, 0});
      tbl.push_back(vec_t'{0, 1, 1, 'h32, 0, 'h8000, 0, 2, 0});
      tbl.push_back(vec_t'{0, 1, 0, 'h32, 0, 'hFFFF8000, 0, 2, 0});
      tbl.push_back(vec_t'{0, 0, 1, 'h31, 0, 'hF0, 0, 2, 0});
`ifdef MISALIGN_TRAP_EN
      tbl.push_back(vec_t'{0, 2, 0, 'h13, 0, 0, 1, 1, 0});
`else
      tbl.push_back(vec_t'{0, 2, 0, 'h13, 0, 'hDEADBEEF, 0, 2, 0});
`endif
      tbl.push_back(vec_t'{1, 0, 0, 'h1011, 'h55, 0, 0, 3, 'hDEAD55EF});
      tbl.push_back(vec_t'{0, 2, 0, 'h10, 0, 'hDEAD55EF, 0, 2, 0});

      foreach (tbl[i]) begin
         run_op(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].ad, tbl[i].wd, 0,
                rd, er, lat, nwe, wa, wdat);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
         chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
         chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("tbl%0d_nwe", i), nwe, (tbl[i].we && !tbl[i].er) ? 1 : 0);
         if (tbl[i].we && !tbl[i].er) begin
            chk($sformatf("tbl%0d_wdata", i), wdat, tbl[i].wdx);
            chk($sformatf("tbl%0d_waddr", i), wa, {22'b0, tbl[i].ad[11:2]});
         end
      end

      // Backpressure: response held for 5 cycles
      req_valid = 1; req_we = 0; req_size = 2; req_addr = 'h20;
      @(posedge clk); #1 req_valid = 0;
      k = 0;
      do begin @(negedge clk); k++; end while (!resp_valid && k < 10);
      hold = resp_rdata;
      chk("bp_first", hold, 'hCAFE3344);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", {31'b0, resp_valid}, 1);
         chk("bp_rdata", resp_rdata, 'hCAFE3344);
         chk("bp_req_ready", {31'b0, req_ready}, 0);
      end
      resp_ready = 1;
      @(posedge clk); #1 resp_ready = 0;
      @(negedge clk);
      chk("bp_release_ready", {31'b0, req_ready}, 1);
      chk("bp_release_valid", {31'b0, resp_valid}, 0);

      // Reset during RMW_RD of a byte store
      req_valid = 1; req_we = 1; req_size = 0; req_addr = 'h30; req_wdata = 'h99;
      @(posedge clk); #1 req_valid = 0;
      chk("mid_busy", {31'b0, busy}, 1);
      rst = 0;
      #1;
      chk("mid_rst_we", {31'b0, mem_we}, 0);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      k = 0;
      repeat (3) begin
         @(negedge clk);
         if (mem_we || resp_valid) k++;
      end
      chk("mid_rst_quiet", k, 0);
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      run_op(0, 2, 0, 'h30, 0, 0, rd, er, lat, nwe, wa, wdat);
      chk("mid_rst_word", rd, 'h8000F07F);

      for (int i = 0; i < 200; i++)
         run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                ($urandom & 32'hFFFFF000) | $urandom_range(0, 63),
                $urandom, 1, rd, er, lat, nwe, wa, wdat);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
